dpwm_controller: RTL and testbench
==================================

Name: dpwm_controller

Overview:
- Sequencing core of the DPWM. Takes already-sanitized duty-cycle, frequency-select and deadtime values, double-buffers them through a valid/ready load port, and commits them only at a period boundary.
- Runs the period counter and drives the complementary high-side/low-side gate outputs with deadtime.
- Handles graceful start and stop of switching.
- Sits between the register/config interface (sanitizer upstream) and the gate-drive pins.

Parameters:
- RESOLUTION, 12, width of the counter and of all timing values.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run request; level-sensitive
- cfg_valid  input  1  new sanitized config offered
- cfg_ready  output  1  controller can accept config
- san_dc  input  RESOLUTION  on-interval length in counts (<= san_fs)
- san_fs  input  RESOLUTION  terminal count; period = san_fs+1 cycles (>= 2)
- san_dt1  input  RESOLUTION  leading deadtime inside on-interval (<= san_dc)
- san_dt2  input  RESOLUTION  leading deadtime inside off-interval (<= san_fs-san_dc)
- pwm_hi  output  1  high-side gate
- pwm_lo  output  1  low-side gate
- period_start  output  1  one-cycle pulse when counter is 0 in RUN/DRAIN
- cnt  output  RESOLUTION  current period count
- running  output  1  high in RUN or DRAIN

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, pwm_hi=pwm_lo=period_start=0, running=0, cfg_ready=1.
  - Pending buffer empty.
  - Active regs: fs_a=2, dc_a=0, dt1_a=0, dt2_a=0.
  - Reset mid-period forces both gates low immediately (asynchronous).
- Config handshake:
  - Transfer when cfg_valid && cfg_ready at a rising edge; all four san_* values are captured into the pending buffer.
  - cfg_ready is a register: low from the cycle after a transfer until the cycle after the pending buffer is committed.
  - cfg_valid while cfg_ready=0 is ignored. The upstream source holds its data.
- Commit rules:
  - RUN/DRAIN: pending is copied to active on the edge where cnt wraps from fs_a to 0. That new period uses the new values.
  - A transfer accepted on the same edge as the wrap is not committed until the following wrap.
  - IDLE: pending commits on the next edge after the transfer.
- State machine:
  - IDLE -> RUN when enable=1. cnt starts at 0 on the next edge.
  - RUN -> DRAIN when enable=0. The current period completes.
  - DRAIN -> RUN if enable returns to 1 before the wrap; cnt is not disturbed.
  - DRAIN -> IDLE at terminal count (cnt==fs_a). cnt returns to 0 and gates go low.
- Counter:
  - In RUN/DRAIN, cnt increments by 1 each cycle and wraps to 0 when cnt==fs_a.
  - Comparisons are unsigned, RESOLUTION bits wide, with no overflow. All addends are bounded by fs_a.
  - In IDLE, cnt is held at 0.
- Gate decode (registered, same edge as cnt; outputs match the current cnt, glitch-free):
  - pwm_hi=1 iff running && dt1_a <= cnt < dc_a.
  - pwm_lo=1 iff running && (dc_a + dt2_a) <= cnt <= fs_a.
  - Shoot-through guard: pwm_lo is forced 0 whenever pwm_hi would be 1, even if the inputs violate the sanitizer contract.
- Boundary conditions:
  - dc_a=0: pwm_hi never asserts. pwm_lo runs from dt2_a to fs_a.
  - dc_a=fs_a with dt2_a=0: pwm_lo asserts only at cnt==fs_a.
  - dt1_a=dc_a: pwm_hi never asserts.
  - enable toggled 1->0->1 within one cycle while in DRAIN: stays in RUN, no gap in switching.
- Latency:
  - enable rise in IDLE to first period_start: 1 cycle.
  - cfg transfer in IDLE to active: 1 cycle.

Test Plan:
- Reset, load fs=9, dc=4, dt1=1, dt2=2 in IDLE, enable=1 -> period 10 cycles; pwm_hi at cnt 1..3; pwm_lo at cnt 6..9; both 0 at cnt 0,4,5; period_start at cnt 0.
- While running, load dc=7 at cnt=3 -> cfg_ready drops; current period unchanged; from next cnt=0 pwm_hi at cnt 1..6 and pwm_lo at cnt 9; cfg_ready returns high 1 cycle after the wrap.
- Offer config on the exact wrap edge (cnt==fs_a) -> value applied one full period later; a second cfg_valid held meanwhile is not accepted until cfg_ready=1.
- Deassert enable at cnt=2 -> gates follow pattern through cnt=9, then IDLE with gates 0 and running=0; reassert at cnt=5 instead -> no interruption.
- Inject illegal values dc=8, dt2=0, fs=5 directly -> pwm_hi and pwm_lo never both 1 in any cycle.
- Assert rst_n=0 asynchronously mid-pulse with pwm_hi=1 -> pwm_hi drops without a clock edge; after release, state IDLE, active fs=2, cfg_ready=1.

Source files
------------

// File: rtl/dpwm_controller.sv
// dpwm_controller: double-buffered DPWM sequencer with deadtime and graceful start/stop
// Ports: clk, rst_n (async active-low); enable run request; cfg_valid/cfg_ready load
// handshake for san_dc/san_fs/san_dt1/san_dt2; pwm_hi/pwm_lo complementary gates;
// period_start pulse at cnt 0; cnt period counter; running high in RUN or DRAIN.
module dpwm_controller #(
  parameter int RESOLUTION = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [RESOLUTION-1:0] san_dc,
  input  logic [RESOLUTION-1:0] san_fs,
  input  logic [RESOLUTION-1:0] san_dt1,
  input  logic [RESOLUTION-1:0] san_dt2,
  output logic                  pwm_hi,
  output logic                  pwm_lo,
  output logic                  period_start,
  output logic [RESOLUTION-1:0] cnt,
  output logic                  running
);
  localparam int W = RESOLUTION;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [W-1:0] fs_a, dc_a, dt1_a, dt2_a;
  logic [W-1:0] fs_p, dc_p, dt1_p, dt2_p;
  logic [W-1:0] fs_n, dc_n, dt1_n, dt2_n, cnt_n;
  logic [W:0] lo_start;
  logic wrap, xfer, commit, restart, run_n, hi_n, lo_n;
  assign running = state != IDLE;
  assign wrap    = running && cnt == fs_a;
  assign xfer    = cfg_valid && cfg_ready;
  // cfg_ready low means the pending buffer holds an uncommitted config
  assign commit  = !cfg_ready && (!running || wrap);
  assign restart = !running || wrap;
  always_comb begin
    state_n  = enable ? RUN : restart ? IDLE : DRAIN;
    cnt_n    = restart ? '0 : cnt + W'(1);
    run_n    = state_n != IDLE;
    {fs_n, dc_n, dt1_n, dt2_n} = commit ? {fs_p, dc_p, dt1_p, dt2_p} : {fs_a, dc_a, dt1_a, dt2_a};
    // widened so out-of-contract dc+dt2 cannot wrap into the on-interval
    lo_start = {1'b0, dc_n} + {1'b0, dt2_n};
    hi_n     = run_n && dt1_n <= cnt_n && cnt_n < dc_n;
    lo_n     = run_n && !hi_n && lo_start <= {1'b0, cnt_n} && cnt_n <= fs_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pwm_hi       <= 1'b0;
      pwm_lo       <= 1'b0;
      period_start <= 1'b0;
      cfg_ready    <= 1'b1;
      fs_a         <= W'(2);
      dc_a         <= '0;
      dt1_a        <= '0;
      dt2_a        <= '0;
      fs_p         <= '0;
      dc_p         <= '0;
      dt1_p        <= '0;
      dt2_p        <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pwm_hi       <= hi_n;
      pwm_lo       <= lo_n;
      period_start <= run_n && cnt_n == '0;
      cfg_ready    <= xfer ? 1'b0 : commit ? 1'b1 : cfg_ready;
      fs_a         <= fs_n;
      dc_a         <= dc_n;
      dt1_a        <= dt1_n;
      dt2_a        <= dt2_n;
      if (xfer) {fs_p, dc_p, dt1_p, dt2_p} <= {san_fs, san_dc, san_dt1, san_dt2};
    end
  end
endmodule

// File: tb/tb_dpwm_controller.sv
// tb_dpwm_controller: randomized self-checking bench for dpwm_controller
module tb_dpwm_controller;
  localparam int W = 12;
  logic clk = 0, rst_n = 0, enable = 0, cfg_valid = 0;
  logic [W-1:0] san_dc = 0, san_fs = 2, san_dt1 = 0, san_dt2 = 0;
  logic cfg_ready, pwm_hi, pwm_lo, period_start, running;
  logic [W-1:0] cnt;
  int nv = 0, nf = 0;
  int m_cnt, a_fs, a_dc, a_dt1, a_dt2, p_fs, p_dc, p_dt1, p_dt2;
  bit m_run, m_ready;
  logic [9:0] hm, lm, sm;
  dpwm_controller #(.RESOLUTION(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .san_dc(san_dc), .san_fs(san_fs), .san_dt1(san_dt1), .san_dt2(san_dt2),
    .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .period_start(period_start), .cnt(cnt), .running(running)
  );
  always #5 clk = ~clk;
  wire [W+4:0] obs = {running, period_start, pwm_hi, pwm_lo, cfg_ready, cnt};
  function automatic logic [W+4:0] expv();
    bit hi, lo;
    hi = m_run && a_dt1 <= m_cnt && m_cnt < a_dc;
    lo = m_run && !hi && a_dc + a_dt2 <= m_cnt && m_cnt <= a_fs;
    return {m_run, m_run && m_cnt == 0, hi, lo, m_ready, W'(m_cnt)};
  endfunction
  task automatic model_reset();
    m_cnt = 0; m_run = 0; m_ready = 1;
    a_fs = 2; a_dc = 0; a_dt1 = 0; a_dt2 = 0;
  endtask
  task automatic step();
    bit was, wrap;
    @(posedge clk);
    was = m_run;
    wrap = m_run && m_cnt == a_fs;
    if (!m_ready && (!was || wrap)) begin
      a_fs = p_fs; a_dc = p_dc; a_dt1 = p_dt1; a_dt2 = p_dt2; m_ready = 1;
    end else if (cfg_valid && m_ready) begin
      p_fs = int'(san_fs); p_dc = int'(san_dc); p_dt1 = int'(san_dt1); p_dt2 = int'(san_dt2); m_ready = 0;
    end
    if (!was || wrap) begin
      m_cnt = 0; m_run = enable;
    end else m_cnt++;
    @(negedge clk);
  endtask
  task automatic offer(input int fs, input int dc, input int dt1, input int dt2);
    san_fs = W'(fs); san_dc = W'(dc); san_dt1 = W'(dt1); san_dt2 = W'(dt2); cfg_valid = 1;
  endtask
  task automatic wait_cnt(input int v);
    int i;
    for (i = 0; i < 200 && cnt !== W'(v); i++) step();
    nv++;
    if (i == 200) begin nf++; $display("FAIL wait_cnt: cnt=%0d never reached %0d", cnt, v); end
  endtask
  task automatic test_reset();
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    nv++; if (obs !== expv()) begin nf++; $display("FAIL reset: got %h want %h", obs, expv()); end
    rst_n = 1;
    step();
    nv++; if (obs !== expv()) begin nf++; $display("FAIL reset_idle: got %h want %h", obs, expv()); end
  endtask
  task automatic test_basic();
    offer(9, 4, 1, 2);
    step();
    nv++; if (obs !== expv()) begin nf++; $display("FAIL basic_xfer: got %h want %h", obs, expv()); end
    cfg_valid = 0;
    step();
    nv++; if (obs !== expv()) begin nf++; $display("FAIL basic_commit: got %h want %h", obs, expv()); end
    enable = 1;
    hm = 0; lm = 0; sm = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      nv++; if (obs !== expv()) begin nf++; $display("FAIL basic_run: got %h want %h", obs, expv()); end
      if (cnt < 10) begin hm[int'(cnt)] = pwm_hi; lm[int'(cnt)] = pwm_lo; sm[int'(cnt)] = period_start; end
    end
    nv++; if (hm !== 10'h00E) begin nf++; $display("FAIL basic_hi_mask: got %h want 00e", hm); end
    nv++; if (lm !== 10'h3C0) begin nf++; $display("FAIL basic_lo_mask: got %h want 3c0", lm); end
    nv++; if (sm !== 10'h001) begin nf++; $display("FAIL basic_ps_mask: got %h want 001", sm); end
  endtask
  task automatic test_midrun_load();
    wait_cnt(3);
    offer(9, 7, 1, 2);
    step();
    nv++; if (cfg_ready !== 1'b0) begin nf++; $display("FAIL midrun_ready: got %b want 0", cfg_ready); end
    cfg_valid = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      nv++; if (obs !== expv()) begin nf++; $display("FAIL midrun: got %h want %h", obs, expv()); end
    end
    wait_cnt(0);
    hm = 0; lm = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      if (cnt < 10) begin hm[int'(cnt)] = pwm_hi; lm[int'(cnt)] = pwm_lo; end
    end
    nv++; if (hm !== 10'h07E) begin nf++; $display("FAIL midrun_hi_mask: got %h want 07e", hm); end
    nv++; if (lm !== 10'h200) begin nf++; $display("FAIL midrun_lo_mask: got %h want 200", lm); end
  endtask
  task automatic test_wrap_load();
    wait_cnt(9);
    offer(9, 5, 1, 2);
    step();
    nv++; if (obs !== expv()) begin nf++; $display("FAIL wrap_xfer: got %h want %h", obs, expv()); end
    offer(9, 2, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step();
      nv++; if (obs !== expv()) begin nf++; $display("FAIL wrap_load: got %h want %h", obs, expv()); end
    end
    cfg_valid = 0;
  endtask
  task automatic test_stop();
    wait_cnt(2);
    enable = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      nv++; if (obs !== expv()) begin nf++; $display("FAIL stop: got %h want %h", obs, expv()); end
    end
    enable = 1;
    wait_cnt(2);
    enable = 0;
    wait_cnt(5);
    enable = 1;
    for (int i = 0; i < 15; i++) begin
      step();
      nv++; if (obs !== expv()) begin nf++; $display("FAIL resume: got %h want %h", obs, expv()); end
    end
    wait_cnt(3);
    enable = 0;
    step();
    enable = 1;
    for (int i = 0; i < 15; i++) begin
      step();
      nv++; if (obs !== expv()) begin nf++; $display("FAIL toggle: got %h want %h", obs, expv()); end
    end
  endtask
  task automatic test_illegal();
    offer(5, 8, 1, 0);
    step();
    cfg_valid = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      nv++; if (obs !== expv()) begin nf++; $display("FAIL illegal: got %h want %h", obs, expv()); end
      nv++; if (pwm_hi && pwm_lo) begin nf++; $display("FAIL shoot_through: hi=%b lo=%b want not both", pwm_hi, pwm_lo); end
    end
  endtask
  task automatic test_random();
    int fs, dc, dt1, dt2, n;
    for (int k = 0; k < 40; k++) begin
      fs = int'($urandom_range(40, 2));
      dc = int'($urandom_range(fs, 0));
      dt1 = int'($urandom_range(dc, 0));
      dt2 = int'($urandom_range(fs - dc, 0));
      offer(fs, dc, dt1, dt2);
      n = int'($urandom_range(60, 5));
      for (int j = 0; j < n; j++) begin
        enable = $urandom_range(7, 0) != 0;
        if (j == 3) cfg_valid = $urandom_range(1, 0) == 1;
        step();
        nv++; if (obs !== expv()) begin nf++; $display("FAIL random: got %h want %h", obs, expv()); end
      end
    end
    cfg_valid = 0;
    enable = 1;
  endtask
  task automatic test_async_reset();
    int i;
    offer(9, 4, 1, 2);
    step();
    cfg_valid = 0;
    for (i = 0; i < 200 && pwm_hi !== 1'b1; i++) step();
    nv++; if (i == 200) begin nf++; $display("FAIL async_wait: pwm_hi=%b never 1", pwm_hi); end
    #2 rst_n = 0;
    #1;
    nv++; if ({pwm_hi, pwm_lo, running} !== 3'b000) begin nf++; $display("FAIL async_drop: got %b want 000", {pwm_hi, pwm_lo, running}); end
    model_reset();
    enable = 0;
    @(negedge clk);
    nv++; if (obs !== expv()) begin nf++; $display("FAIL async_hold: got %h want %h", obs, expv()); end
    rst_n = 1;
    step();
    nv++; if (obs !== expv()) begin nf++; $display("FAIL async_idle: got %h want %h", obs, expv()); end
    enable = 1;
    for (int j = 0; j < 8; j++) begin
      step();
      nv++; if (obs !== expv()) begin nf++; $display("FAIL async_default: got %h want %h", obs, expv()); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_midrun_load();
    test_wrap_load();
    test_stop();
    test_illegal();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
